// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decode handshake and
// downstream redirect.
//   master (if_fetch): drives imem_req/imem_addr and the inst_* payload,
//                      receives imem_rvalid/imem_rdata, inst_ready, redirect.
//   slave  (memory + decode side): the mirror image.
interface if_fetch_if #(
  parameter int unsigned XLEN = 32
);
  // Instruction memory read port
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  // Decode handshake and payload
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pcplus4;

  // Taken branch/jump from downstream
  logic            redirect;
  logic [XLEN-1:0] redirect_target;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pcplus4,
    input  imem_rvalid, imem_rdata, inst_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pcplus4,
    output imem_rvalid, imem_rdata, inst_ready, redirect, redirect_target
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Owns the PC, keeps at most one instruction-memory
// read outstanding, hands each fetched word (with its PC and PC+4) to decode
// over a valid/ready handshake and squashes wrong-path fetches on redirect.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - if_fetch_if.master: imem_* read port, inst_* decode handshake,
//          redirect/redirect_target
module if_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);

  localparam logic [31:0]     NOP_INST   = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  // REQ: issue read; WAIT: read in flight; HOLD: word offered to decode;
  // DROP: in-flight read was made wrong-path by a redirect.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] inst_pcplus4_q, inst_pcplus4_d;
  logic [XLEN-1:0] target_c;
  logic            req_c;
  logic            valid_c;

  // No compressed support: targets are forced to word alignment.
  assign target_c = bus.redirect_target & ALIGN_MASK;

  // State and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_REQ;
      pc_q           <= RESET_PC;
      inst_q         <= NOP_INST;
      inst_pc_q      <= RESET_PC;
      inst_pcplus4_q <= RESET_PC + PC_STEP;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      inst_pc_q      <= inst_pc_d;
      inst_pcplus4_q <= inst_pcplus4_d;
    end
  end

  // Next-state, PC update and handshake strobes
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    inst_pcplus4_d = inst_pcplus4_q;
    req_c          = 1'b0;
    valid_c        = 1'b0;

    case (state_q)
      S_REQ: begin
        if (bus.redirect) begin
          pc_d = target_c;
        end else begin
          req_c   = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.redirect) begin
          pc_d = target_c;
          // Response already here is simply dropped; otherwise wait it out.
          state_d = bus.imem_rvalid ? S_REQ : S_DROP;
        end else if (bus.imem_rvalid) begin
          inst_d         = bus.imem_rdata;
          inst_pc_d      = pc_q;
          inst_pcplus4_d = pc_q + PC_STEP;
          state_d        = S_HOLD;
        end
      end

      S_DROP: begin
        if (bus.redirect) begin
          pc_d = target_c;
        end
        // The stale response retires the outstanding read.
        if (bus.imem_rvalid) begin
          state_d = S_REQ;
        end
      end

      S_HOLD: begin
        valid_c = ~bus.redirect;
        if (bus.redirect) begin
          pc_d    = target_c;
          state_d = S_REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Strobes are masked during reset so nothing leaks out of an aborted state.
  assign bus.imem_req     = req_c & ~rst;
  assign bus.imem_addr    = pc_q;
  assign bus.inst_valid   = valid_c & ~rst;
  assign bus.inst         = inst_q;
  assign bus.inst_pc      = inst_pc_q;
  assign bus.inst_pcplus4 = inst_pcplus4_q;

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios plus a randomized run checked by
// a transaction-level model of the fetch stream.
module tb_if_fetch;

  localparam logic [31:0] RPC_A = 32'h0000_0100;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_if #(.XLEN(32)) bus_a ();
  if_fetch_if #(.XLEN(32)) bus_b ();

  if_fetch #(.XLEN(32), .RESET_PC(RPC_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  if_fetch #(.XLEN(32), .RESET_PC(RPC_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: a scrambled function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_A5A5;
  endfunction

  // Instruction memory for dut_a: fixed latency per request, reset with core.
  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  always @(posedge clk) begin
    bus_a.imem_rvalid <= 1'b0;
    if (rst) begin
      mem_cnt = 0;
    end else begin
      if (mem_cnt != 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus_a.imem_rvalid <= 1'b1;
          bus_a.imem_rdata  <= mem_word(mem_addr);
        end
      end
      if (bus_a.imem_req) begin
        mem_addr = bus_a.imem_addr;
        if (mem_lat <= 1) begin
          bus_a.imem_rvalid <= 1'b1;
          bus_a.imem_rdata  <= mem_word(bus_a.imem_addr);
        end else begin
          mem_cnt = mem_lat - 1;
        end
      end
    end
  end

  // Event logs for the directed scenarios.
  int          req_cyc_q[$];
  logic [31:0] req_addr_q[$];
  int          take_cyc_q[$];
  logic [31:0] take_pc_q[$];
  logic [31:0] take_p4_q[$];

  // Transaction model: the next fetch address follows the last consumed
  // instruction (+4) or the last redirect; a delivered word must belong to
  // the latest request that has not been squashed or consumed.
  logic [31:0] m_exp_pc   = RPC_A;
  logic [31:0] m_last     = '0;
  bit          m_have_req = 0;
  bit          m_squashed = 0;
  bit          m_consumed = 0;
  bit          m_got_resp = 0;
  bit          m_outst    = 0;
  int          m_idle     = 0;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (bus_a.imem_req !== 1'b0 || bus_a.inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_strobes: req=%b valid=%b, want 0/0", bus_a.imem_req, bus_a.inst_valid);
      end
      m_exp_pc   = RPC_A;
      m_have_req = 0;
      m_squashed = 0;
      m_consumed = 0;
      m_got_resp = 0;
      m_outst    = 0;
      m_idle     = 0;
    end else begin
      m_idle++;
      if (bus_a.inst_valid) begin
        checks++;
        if (!m_have_req || m_squashed || m_consumed || !m_got_resp ||
            bus_a.inst_pc !== m_last || bus_a.inst !== mem_word(m_last) ||
            bus_a.inst_pcplus4 !== m_last + 32'd4) begin
          errors++;
          $display("FAIL model_deliver: inst=%h pc=%h p4=%h, want inst=%h pc=%h (sq=%0d cons=%0d resp=%0d)",
                   bus_a.inst, bus_a.inst_pc, bus_a.inst_pcplus4, mem_word(m_last), m_last,
                   m_squashed, m_consumed, m_got_resp);
        end
        if (bus_a.inst_ready) begin
          m_consumed = 1;
          m_exp_pc   = m_last + 32'd4;
          m_idle     = 0;
          take_cyc_q.push_back(cyc);
          take_pc_q.push_back(bus_a.inst_pc);
          take_p4_q.push_back(bus_a.inst_pcplus4);
        end
      end
      if (bus_a.imem_req) begin
        checks++;
        if (bus_a.imem_addr !== m_exp_pc || m_outst ||
            (m_have_req && m_got_resp && !m_squashed && !m_consumed)) begin
          errors++;
          $display("FAIL model_req: addr=%h, want %h (outstanding=%0d)", bus_a.imem_addr, m_exp_pc, m_outst);
        end
        req_cyc_q.push_back(cyc);
        req_addr_q.push_back(bus_a.imem_addr);
        m_last     = bus_a.imem_addr;
        m_have_req = 1;
        m_squashed = 0;
        m_consumed = 0;
        m_got_resp = 0;
        m_outst    = 1;
        m_idle     = 0;
      end
      if (bus_a.redirect) begin
        m_exp_pc   = bus_a.redirect_target & 32'hFFFF_FFFC;
        m_squashed = 1;
      end
      if (bus_a.imem_rvalid) begin
        m_outst    = 0;
        m_got_resp = 1;
      end
      if (m_idle > 50) begin
        checks++;
        errors++;
        $display("FAIL progress: no request or consume for %0d cycles at cycle %0d", m_idle, cyc);
        m_idle = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_cyc_q.delete();
    req_addr_q.delete();
    take_cyc_q.delete();
    take_pc_q.delete();
    take_p4_q.delete();
  endtask

  // Two reset edges; returns at the start of the first post-reset cycle.
  task automatic do_reset();
    rst = 1'b1;
    bus_a.redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (bus_a.inst !== NOP || bus_a.inst_pc !== RPC_A || bus_a.inst_pcplus4 !== RPC_A + 32'd4 ||
        bus_a.imem_addr !== RPC_A) begin
      errors++;
      $display("FAIL reset_values: inst=%h pc=%h p4=%h addr=%h, want %h %h %h %h",
               bus_a.inst, bus_a.inst_pc, bus_a.inst_pcplus4, bus_a.imem_addr,
               NOP, RPC_A, RPC_A + 32'd4, RPC_A);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== RPC_A || bus_a.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h valid=%b, want 1 %h 0",
               bus_a.imem_req, bus_a.imem_addr, bus_a.inst_valid, RPC_A);
    end
  endtask

  task automatic test_sequential();
    int c0;
    mem_lat = 1;
    bus_a.inst_ready = 1'b1;
    do_reset();
    c0 = cyc;
    repeat (8) tick();
    checks++;
    if (req_addr_q.size() < 3 || take_pc_q.size() < 2) begin
      errors++;
      $display("FAIL seq_count: reqs=%0d takes=%0d, want >=3 >=2", req_addr_q.size(), take_pc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (req_addr_q[i] !== RPC_A + 32'(4 * i) || req_cyc_q[i] != c0 + 3 * i) begin
          errors++;
          $display("FAIL seq_req%0d: addr=%h cyc=%0d, want %h %0d",
                   i, req_addr_q[i], req_cyc_q[i], RPC_A + 32'(4 * i), c0 + 3 * i);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (take_pc_q[i] !== RPC_A + 32'(4 * i) || take_p4_q[i] !== RPC_A + 32'(4 * i + 4) ||
            take_cyc_q[i] != c0 + 2 + 3 * i) begin
          errors++;
          $display("FAIL seq_take%0d: pc=%h p4=%h cyc=%0d, want %h %h %0d", i, take_pc_q[i], take_p4_q[i],
                   take_cyc_q[i], RPC_A + 32'(4 * i), RPC_A + 32'(4 * i + 4), c0 + 2 + 3 * i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    mem_lat = 1;
    bus_a.inst_ready = 1'b0;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus_a.inst_valid !== 1'b1 || bus_a.inst !== mem_word(RPC_A) || bus_a.inst_pc !== RPC_A ||
          bus_a.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b inst=%h pc=%h req=%b, want 1 %h %h 0",
                 i, bus_a.inst_valid, bus_a.inst, bus_a.inst_pc, bus_a.imem_req, mem_word(RPC_A), RPC_A);
      end
      tick();
    end
    bus_a.inst_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== RPC_A + 32'd4) begin
      errors++;
      $display("FAIL bp_release: req=%b addr=%h, want 1 %h", bus_a.imem_req, bus_a.imem_addr, RPC_A + 32'd4);
    end
  endtask

  task automatic test_redirect_hold();
    mem_lat = 1;
    bus_a.inst_ready = 1'b1;
    do_reset();
    tick();
    tick();
    bus_a.redirect = 1'b1;
    bus_a.redirect_target = 32'h0000_0203;
    @(negedge clk);
    checks++;
    if (bus_a.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdh_valid: valid=%b, want 0", bus_a.inst_valid);
    end
    tick();
    bus_a.redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 32'h0000_0200 || take_pc_q.size() != 0) begin
      errors++;
      $display("FAIL rdh_target: req=%b addr=%h takes=%0d, want 1 00000200 0",
               bus_a.imem_req, bus_a.imem_addr, take_pc_q.size());
    end
  endtask

  task automatic test_redirect_wait();
    bit got;
    mem_lat = 4;
    bus_a.inst_ready = 1'b1;
    do_reset();
    tick();
    bus_a.redirect = 1'b1;
    bus_a.redirect_target = 32'h0000_0300;
    tick();
    bus_a.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus_a.imem_req !== 1'b0 || bus_a.inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL rdw_drop%0d: req=%b valid=%b, want 0 0", i, bus_a.imem_req, bus_a.inst_valid);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 32'h0000_0300) begin
      errors++;
      $display("FAIL rdw_target: req=%b addr=%h, want 1 00000300", bus_a.imem_req, bus_a.imem_addr);
    end
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      @(negedge clk);
      if (bus_a.inst_valid) got = 1;
    end
    checks++;
    if (!got || bus_a.inst !== mem_word(32'h300) || bus_a.inst_pc !== 32'h300) begin
      errors++;
      $display("FAIL rdw_deliver: seen=%0d inst=%h pc=%h, want 1 %h 00000300",
               got, bus_a.inst, bus_a.inst_pc, mem_word(32'h300));
    end
    mem_lat = 1;
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus_b.imem_req !== 1'b1 || bus_b.imem_addr !== RPC_B) begin
      errors++;
      $display("FAIL wrap_req0: req=%b addr=%h, want 1 %h", bus_b.imem_req, bus_b.imem_addr, RPC_B);
    end
    tick();
    bus_b.imem_rvalid = 1'b1;
    bus_b.imem_rdata  = 32'h0040_0093;
    tick();
    bus_b.imem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_b.inst_valid !== 1'b1 || bus_b.inst_pc !== RPC_B || bus_b.inst_pcplus4 !== 32'h0 ||
        bus_b.inst !== 32'h0040_0093) begin
      errors++;
      $display("FAIL wrap_hold: valid=%b pc=%h p4=%h inst=%h, want 1 %h 00000000 00400093",
               bus_b.inst_valid, bus_b.inst_pc, bus_b.inst_pcplus4, bus_b.inst, RPC_B);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus_b.imem_req !== 1'b1 || bus_b.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_req1: req=%b addr=%h, want 1 00000000", bus_b.imem_req, bus_b.imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    mem_lat = 1;
    bus_a.inst_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    mem_lat = 4;
    @(negedge clk);
    checks++;
    if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== RPC_A + 32'd4) begin
      errors++;
      $display("FAIL rmw_req: req=%b addr=%h, want 1 %h", bus_a.imem_req, bus_a.imem_addr, RPC_A + 32'd4);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.inst !== mem_word(RPC_A)) begin
      errors++;
      $display("FAIL rmw_pre: inst=%h, want %h", bus_a.inst, mem_word(RPC_A));
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.inst_valid !== 1'b0 || bus_a.inst !== NOP || bus_a.inst_pc !== RPC_A ||
        bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== RPC_A) begin
      errors++;
      $display("FAIL rmw_after: valid=%b inst=%h pc=%h req=%b addr=%h, want 0 %h %h 1 %h",
               bus_a.inst_valid, bus_a.inst, bus_a.inst_pc, bus_a.imem_req, bus_a.imem_addr, NOP, RPC_A, RPC_A);
    end
    repeat (12) tick();
    mem_lat = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      tick();
      mem_lat          = int'($urandom_range(1, 4));
      bus_a.inst_ready = ($urandom_range(0, 3) != 0);
      bus_a.redirect   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        bus_a.redirect_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        bus_a.redirect_target = $urandom;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    bus_a.redirect   = 1'b0;
    bus_a.inst_ready = 1'b1;
    mem_lat = 1;
    repeat (10) tick();
  endtask

  initial begin
    bus_a.inst_ready      = 1'b1;
    bus_a.redirect        = 1'b0;
    bus_a.redirect_target = '0;
    bus_a.imem_rvalid     = 1'b0;
    bus_a.imem_rdata      = '0;
    bus_b.inst_ready      = 1'b1;
    bus_b.redirect        = 1'b0;
    bus_b.redirect_target = '0;
    bus_b.imem_rvalid     = 1'b0;
    bus_b.imem_rdata      = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_hold();
    test_redirect_wait();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the single-cycle RISC-V core, directly upstream of the ID-stage decode and control logic. Owns the program counter and issues one instruction-memory read at a time. Presents each fetched instruction, its PC and PC+4 to decode through a valid/ready handshake. Accepts branch/jump redirects from downstream and squashes any wrong-path fetch in flight.

## Interface
- `XLEN`, 32, address/data width; fixed at 32 for RV32I.
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request, one-cycle pulse per fetch.
- `imem_addr`  out  XLEN  word address of request (equals `pc`).
- `imem_rvalid`  in  1  read data valid; earliest one cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode consumes instruction this cycle.
- `inst`  out  32  instruction word; `inst[6:0]` is the opcode field used by control.
- `inst_pc`  out  XLEN  PC of `inst`.
- `inst_pcplus4`  out  XLEN  `inst_pc + 4`, feeds the JAL link path.
- `redirect`  in  1  taken branch/jump from downstream.
- `redirect_target`  in  XLEN  new PC; bits [1:0] masked to 0.

## Operation
- States: REQ, WAIT, HOLD, DROP. At most one memory read outstanding.
- `imem_req = (state==REQ) && !redirect && !rst`; `imem_addr = pc`.
- `inst_valid = (state==HOLD) && !redirect`.
- REQ: no redirect -> issue request, go WAIT. Redirect -> no request, `pc <= target`, stay REQ.
- WAIT:
  - rvalid, no redirect -> latch `inst <= imem_rdata`, `inst_pc <= pc`; go HOLD.
  - redirect with rvalid -> discard data, `pc <= target`, go REQ.
  - redirect without rvalid -> `pc <= target`, go DROP.
  - otherwise stay.
- DROP: in-flight response is wrong-path. On rvalid, discard it and go REQ. Redirect here only updates `pc` and stays DROP.
- HOLD:
  - redirect has priority over ready: `pc <= target`, instruction discarded, go REQ.
  - ready, no redirect -> `pc <= pc + 4`, go REQ.
  - otherwise hold `inst`, `inst_pc` stable.
- Arithmetic: `pc + 4` and `inst_pcplus4` wrap modulo 2^32. `pc[1:0]` always 0; no compressed support.
- `imem_rvalid` in REQ or HOLD is a protocol error. Ignore it; do not change state.

## Timing
- Reset values (while `rst` high and the cycle after):
  - `pc = RESET_PC`, state = REQ.
  - `inst = 32'h0000_0013` (nop), `inst_pc = RESET_PC`, `inst_pcplus4 = RESET_PC + 4`.
  - `imem_req = 0` and `inst_valid = 0` during reset.
- `rst` mid-operation: aborts any state next edge. A later `imem_rvalid` from the aborted fetch must arrive before the next REQ completes; the memory is reset with the core.
- First request: cycle after `rst` deasserts.
- Latency with `imem_rvalid` one cycle after request and `inst_ready` held high:
  - request at cycle N, data at N+1, `inst_valid` at N+2, next request at N+3.
  - Steady throughput: 1 instruction / 3 cycles.
- `inst`, `inst_pc`, `inst_pcplus4` are registered; they change only on the WAIT->HOLD edge or reset.
- Redirect takes effect at the next edge. The first request to the target issues the cycle after redirect from REQ/WAIT(+rvalid)/HOLD, or the cycle after the wrong-path rvalid from DROP.

## Test plan
- Reset/sequential fetch: `RESET_PC=0x100`, memory returns rdata=addr, 1-cycle latency, ready=1 -> requests at 0x100, 0x104, 0x108 spaced 3 cycles; `inst_pc`/`inst_pcplus4` = 0x100/0x104, 0x104/0x108.
- Backpressure: ready=0 for 5 cycles in HOLD -> `inst_valid` stays 1; `inst` and `inst_pc` stable; no `imem_req`; next request at `inst_pc+4` one cycle after ready=1.
- Redirect in HOLD with ready=1, target 0x203 -> instruction not consumed; next request addr 0x200.
- Redirect in WAIT, memory latency 4 -> state DROP; wrong-path rdata never appears on `inst`. Request to target issues the cycle after the stale rvalid.
- Wrap-around: `RESET_PC=0xFFFF_FFFC` -> `inst_pcplus4=0`; second request addr 0x0000_0000.
- Reset mid-WAIT: assert `rst` 1 cycle -> `inst_valid=0`, `inst=0x13`. First request after release is at `RESET_PC`.
